// File: rtl/prog_seq_if.sv
// Handshake/control bundle between the program sequencer and its control/ROM side.
interface prog_seq_if #(
    parameter int D     = 12,
    parameter int OFS_W = 8
);
    logic             start;
    logic [8:0]       mach_code;
    logic             stall;
    logic             abs_jump;
    logic [D-1:0]     target;
    logic             branch_en;
    logic             branch_taken;
    logic [OFS_W-1:0] rel_ofs;
    logic [D-1:0]     prog_ctr;
    logic             busy;
    logic             instr_valid;
    logic             done;

    modport master (
        output start, mach_code, stall, abs_jump, target, branch_en, branch_taken, rel_ofs,
        input  prog_ctr, busy, instr_valid, done
    );

    modport slave (
        input  start, mach_code, stall, abs_jump, target, branch_en, branch_taken, rel_ofs,
        output prog_ctr, busy, instr_valid, done
    );
endinterface

// File: rtl/prog_seq.sv
// Program-counter sequencer: start/halt handshake, fetch, absolute jumps, relative branches.
// Optional run-cycle counter port enabled by PROG_SEQ_CYCLE_CNT_EN.
module prog_seq #(
    parameter int           D         = 12,
    parameter int           OFS_W     = 8,
    parameter logic [8:0]   HALT_CODE = 9'b111111111,
    parameter logic [D-1:0] START_PC  = '0
) (
    input  logic        Clk,
    input  logic        Reset,
    prog_seq_if.slave   bus
`ifdef PROG_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t       state, state_nxt;
    logic [D-1:0] pc, pc_nxt;
    logic         done_q;
    logic         is_halt;
    logic [D-1:0] ofs_ext;

    assign is_halt = (bus.mach_code == HALT_CODE);
    assign ofs_ext = {{(D-OFS_W){bus.rel_ofs[OFS_W-1]}}, bus.rel_ofs};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            pc     <= START_PC;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            done_q <= (state_nxt == HALT);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                end
            end
            RUN: begin
                // Stall outranks halt so a halt code under stall is not acted on yet.
                if (bus.stall) begin
                    pc_nxt = pc;
                end else if (is_halt) begin
                    state_nxt = HALT;
                end else if (bus.abs_jump) begin
                    pc_nxt = bus.target;
                end else if (bus.branch_en && bus.branch_taken) begin
                    pc_nxt = pc + ofs_ext;
                end else begin
                    pc_nxt = pc + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = START_PC;
            end
        endcase
    end

    assign bus.prog_ctr    = pc;
    assign bus.busy        = (state == RUN);
    assign bus.done        = done_q;
    assign bus.instr_valid = (state == RUN) & ~bus.stall & ~is_halt;

`ifdef PROG_SEQ_CYCLE_CNT_EN
    logic start_acc;
    assign start_acc = bus.start & (state != RUN);

    always_ff @(posedge Clk) begin
        if (Reset || start_acc)
            cycle_cnt <= '0;
        else if (state == RUN && cycle_cnt != 16'hFFFF)
            cycle_cnt <= cycle_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq: ROM model, expected PC/busy/done queued per step and checked after each edge.
module tb_prog_seq;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    prog_seq_if #(.D(12), .OFS_W(8)) bus ();
    logic [8:0] rom [4096];
    assign bus.mach_code = rom[bus.prog_ctr];

`ifdef PROG_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
    prog_seq dut (.Clk(Clk), .Reset(Reset), .bus(bus), .cycle_cnt(cycle_cnt));
`else
    prog_seq dut (.Clk(Clk), .Reset(Reset), .bus(bus));
`endif

    typedef struct {
        logic [11:0] pc;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;
    int    iv_cnt = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Push expectation, clock one edge, then pop and compare what the DUT produced.
    task automatic step(string tag, logic [11:0] pc, logic busy, logic done);
        exp_t e;
        exp_t x;
        string t;
        e.pc = pc; e.busy = busy; e.done = done;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        iv_cnt += int'(bus.instr_valid);
        @(posedge Clk);
        #1;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            t = tag_q.pop_front();
            check(t, {18'd0, bus.prog_ctr, bus.busy, bus.done}, {18'd0, x.pc, x.busy, x.done});
        end
    endtask

    task automatic check_iv(string tag, logic exp);
        #1;
        check(tag, {31'd0, bus.instr_valid}, {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 9'h000;
        rom[5] = 9'h1FF;
        Reset = 1'b1;
        bus.start = 0; bus.stall = 0; bus.abs_jump = 0; bus.target = '0;
        bus.branch_en = 0; bus.branch_taken = 0; bus.rel_ofs = '0;
        @(posedge Clk); #1;
        step("reset", 12'h000, 0, 0);
        check_iv("reset_iv", 0);
        Reset = 1'b0;
        step("idle_hold", 12'h000, 0, 0);

        // Run 0..5 with a 2-cycle stall at PC=2; halt code at 5.
        iv_cnt = 0;
        bus.start = 1;
        step("start", 12'h000, 1, 0);
        bus.start = 0;
        check_iv("run_iv", 1);
        step("pc1", 12'h001, 1, 0);
        bus.start = 1;
        step("pc2_start_ign", 12'h002, 1, 0);
        bus.start = 0;
        bus.stall = 1;
        check_iv("stall_iv", 0);
        step("stall_a", 12'h002, 1, 0);
        step("stall_b", 12'h002, 1, 0);
        bus.stall = 0;
        step("pc3", 12'h003, 1, 0);
        step("pc4", 12'h004, 1, 0);
        step("pc5", 12'h005, 1, 0);
        check_iv("halt_code_iv", 0);
        step("halt_enter", 12'h005, 0, 1);
        check("iv_cycles", iv_cnt, 5);
`ifdef PROG_SEQ_CYCLE_CNT_EN
        check("cnt_halt", {16'd0, cycle_cnt}, 32'd8);
`endif
        step("halt_hold", 12'h005, 0, 1);

        // Restart from HALT; jumps, branches, wrap.
        rom[5] = 9'h000;
        rom[7] = 9'h1FF;
        bus.start = 1;
        step("restart", 12'h000, 1, 0);
        bus.start = 0;
`ifdef PROG_SEQ_CYCLE_CNT_EN
        check("cnt_clear", {16'd0, cycle_cnt}, 32'd0);
`endif
        step("r_pc1", 12'h001, 1, 0);
        step("r_pc2", 12'h002, 1, 0);
        step("r_pc3", 12'h003, 1, 0);
        bus.abs_jump = 1; bus.target = 12'h100;
        bus.branch_en = 1; bus.branch_taken = 1; bus.rel_ofs = 8'h05;
        step("jump_wins", 12'h100, 1, 0);
        bus.abs_jump = 0; bus.branch_en = 0; bus.branch_taken = 0;
        step("after_jump", 12'h101, 1, 0);
        bus.abs_jump = 1; bus.target = 12'h010;
        step("jump_010", 12'h010, 1, 0);
        bus.abs_jump = 0;
        bus.branch_en = 1; bus.branch_taken = 1; bus.rel_ofs = 8'hF0;
        step("br_neg16", 12'h000, 1, 0);
        bus.branch_en = 0; bus.branch_taken = 0;
        step("b_pc1", 12'h001, 1, 0);
        step("b_pc2", 12'h002, 1, 0);
        bus.branch_en = 1; bus.branch_taken = 1; bus.rel_ofs = 8'hFC;
        step("br_wrap", 12'hFFE, 1, 0);
        bus.branch_taken = 0;
        step("br_not_taken", 12'hFFF, 1, 0);
        bus.branch_en = 0;
        step("inc_wrap", 12'h000, 1, 0);

        // Stall with a halt code presented at PC=7.
        bus.abs_jump = 1; bus.target = 12'h007;
        step("jump_7", 12'h007, 1, 0);
        bus.abs_jump = 0;
        bus.stall = 1;
        check_iv("stall7_iv", 0);
        step("stall7_a", 12'h007, 1, 0);
        step("stall7_b", 12'h007, 1, 0);
        step("stall7_c", 12'h007, 1, 0);
        bus.stall = 0;
        check_iv("halt7_iv", 0);
        step("halt7", 12'h007, 0, 1);

        // Reset mid-RUN.
        bus.start = 1;
        step("restart2", 12'h000, 1, 0);
        bus.start = 0;
        step("rr_pc1", 12'h001, 1, 0);
        Reset = 1;
        step("reset_midrun", 12'h000, 0, 0);
        Reset = 0;
        step("idle_after", 12'h000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
